// File: rtl/id_ex_pipeline_register.sv
// ---------------------------------------------------------------------------
// id_ex_pipeline_register
//   ID/EX pipeline register of a five-stage RISC core. Each advancing clock
//   takes one of three actions, highest priority first:
//     flush : a bubble is loaded because EX resolved a taken branch or jump
//     stall : a bubble is loaded because hazard detection holds ID
//     pass  : the ID-stage fields are copied into the EX slot
//   The block also keeps saturating statistics counters and a stall watchdog
//   that raises a sticky error after STALL_LIMIT consecutive stalls.
//
// Ports
//   CLK, CLR_N            clock, asynchronous active-low reset
//   EN                    global advance enable (0 freezes everything)
//   Stall_PC_ID, Flush    bubble requests (Flush has priority)
//   Cnt_Clr               synchronous clear of counters and Stall_Err
//   *_in / *_out          ID-stage fields and their registered EX copies
//   Valid_out, Bubble_out EX slot holds a real instruction / a bubble
//   Stall_Cnt, Flush_Cnt, Instr_Cnt   saturating statistics counters
//   Stall_Err             sticky stall-watchdog flag
// ---------------------------------------------------------------------------
module id_ex_pipeline_register #(
    parameter int DATA_W      = 32,
    parameter int CNT_W       = 16,
    parameter int STALL_LIMIT = 3
) (
    input  logic              CLK,
    input  logic              CLR_N,
    input  logic              EN,
    input  logic              Stall_PC_ID,
    input  logic              Flush,
    input  logic              Cnt_Clr,
    input  logic [DATA_W-1:0] PC_in,
    input  logic [DATA_W-1:0] IR_in,
    input  logic [DATA_W-1:0] R1_in,
    input  logic [DATA_W-1:0] R2_in,
    input  logic [DATA_W-1:0] Imm_in,
    input  logic [4:0]        WAdr_in,
    input  logic              R1_CF_in,
    input  logic              R2_CF_in,
    input  logic              RegWrite_in,
    input  logic              MemWrite_in,
    input  logic              MemToReg_in,
    input  logic              AluSrc_in,
    input  logic              Halt_in,
    input  logic [3:0]        AluOp_in,
    output logic [DATA_W-1:0] PC_out,
    output logic [DATA_W-1:0] IR_out,
    output logic [DATA_W-1:0] R1_out,
    output logic [DATA_W-1:0] R2_out,
    output logic [DATA_W-1:0] Imm_out,
    output logic [4:0]        WAdr_out,
    output logic              R1_CF_out,
    output logic              R2_CF_out,
    output logic              RegWrite_out,
    output logic              MemWrite_out,
    output logic              MemToReg_out,
    output logic              AluSrc_out,
    output logic              Halt_out,
    output logic [3:0]        AluOp_out,
    output logic              Valid_out,
    output logic              Bubble_out,
    output logic [CNT_W-1:0]  Stall_Cnt,
    output logic [CNT_W-1:0]  Flush_Cnt,
    output logic [CNT_W-1:0]  Instr_Cnt,
    output logic              Stall_Err
);

    localparam int RUN_W = (STALL_LIMIT < 1) ? 1 : $clog2(STALL_LIMIT + 1);
    localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(STALL_LIMIT);

    typedef enum logic {RUN = 1'b0, ERR = 1'b1} wd_state_t;

    wd_state_t        wd_state;
    logic [RUN_W-1:0] run_cnt;
    logic [RUN_W-1:0] run_inc;
    logic             do_flush;
    logic             do_stall;
    logic             do_pass;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    // Flush wins over stall: a bubble from a flush is never counted as a stall.
    assign do_flush = Flush;
    assign do_stall = !Flush && Stall_PC_ID;
    assign do_pass  = !Flush && !Stall_PC_ID;

    assign run_inc = (run_cnt == RUN_MAX) ? run_cnt : run_cnt + RUN_W'(1);

    // Pipeline register
    always_ff @(posedge CLK or negedge CLR_N) begin
        if (!CLR_N) begin
            PC_out       <= '0;
            IR_out       <= '0;
            R1_out       <= '0;
            R2_out       <= '0;
            Imm_out      <= '0;
            WAdr_out     <= '0;
            R1_CF_out    <= 1'b0;
            R2_CF_out    <= 1'b0;
            RegWrite_out <= 1'b0;
            MemWrite_out <= 1'b0;
            MemToReg_out <= 1'b0;
            AluSrc_out   <= 1'b0;
            Halt_out     <= 1'b0;
            AluOp_out    <= '0;
            Valid_out    <= 1'b0;
            Bubble_out   <= 1'b0;
        end else if (EN) begin
            // PC follows even into a bubble so a debug trace can see where
            // the bubble was inserted. Operand/immediate data is harmless in
            // a bubble because every control bit that could use it is zero.
            PC_out  <= PC_in;
            R1_out  <= R1_in;
            R2_out  <= R2_in;
            Imm_out <= Imm_in;
            if (do_pass) begin
                IR_out       <= IR_in;
                WAdr_out     <= WAdr_in;
                R1_CF_out    <= R1_CF_in;
                R2_CF_out    <= R2_CF_in;
                RegWrite_out <= RegWrite_in;
                MemWrite_out <= MemWrite_in;
                MemToReg_out <= MemToReg_in;
                AluSrc_out   <= AluSrc_in;
                Halt_out     <= Halt_in;
                AluOp_out    <= AluOp_in;
                Valid_out    <= 1'b1;
                Bubble_out   <= 1'b0;
            end else begin
                IR_out       <= '0;
                WAdr_out     <= '0;
                R1_CF_out    <= 1'b0;
                R2_CF_out    <= 1'b0;
                RegWrite_out <= 1'b0;
                MemWrite_out <= 1'b0;
                MemToReg_out <= 1'b0;
                AluSrc_out   <= 1'b0;
                Halt_out     <= 1'b0;
                AluOp_out    <= '0;
                Valid_out    <= 1'b0;
                Bubble_out   <= 1'b1;
            end
        end
    end

    // Statistics counters
    always_ff @(posedge CLK or negedge CLR_N) begin
        if (!CLR_N) begin
            Stall_Cnt <= '0;
            Flush_Cnt <= '0;
            Instr_Cnt <= '0;
        end else if (EN) begin
            if (Cnt_Clr) begin
                Stall_Cnt <= '0;
                Flush_Cnt <= '0;
                Instr_Cnt <= '0;
            end else begin
                if (do_flush) Flush_Cnt <= sat_inc(Flush_Cnt);
                if (do_stall) Stall_Cnt <= sat_inc(Stall_Cnt);
                if (do_pass)  Instr_Cnt <= sat_inc(Instr_Cnt);
            end
        end
    end

    // Stall watchdog: run counter plus RUN/ERR state with a registered flag
    always_ff @(posedge CLK or negedge CLR_N) begin
        if (!CLR_N) begin
            run_cnt   <= '0;
            wd_state  <= RUN;
            Stall_Err <= 1'b0;
        end else if (EN) begin
            // The run counter tracks consecutive stall actions only; it is
            // independent of Cnt_Clr.
            run_cnt <= do_stall ? run_inc : '0;
            case (wd_state)
                RUN: begin
                    if (!Cnt_Clr && do_stall && run_inc == RUN_MAX) begin
                        wd_state  <= ERR;
                        Stall_Err <= 1'b1;
                    end
                end
                ERR: begin
                    if (Cnt_Clr) begin
                        wd_state  <= RUN;
                        Stall_Err <= 1'b0;
                    end
                end
                default: begin
                    wd_state  <= RUN;
                    Stall_Err <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_id_ex_pipeline_register.sv
module tb_id_ex_pipeline_register;

    localparam int DATA_W  = 32;
    localparam int LIMIT   = 3;
    localparam int SCNT_W  = 3;
    localparam int MAX_D   = 65535;
    localparam int MAX_S   = 7;

    logic CLK = 1'b0;
    logic CLR_N, EN, Stall_PC_ID, Flush, Cnt_Clr;
    logic [DATA_W-1:0] PC_in, IR_in, R1_in, R2_in, Imm_in;
    logic [4:0] WAdr_in;
    logic R1_CF_in, R2_CF_in, RegWrite_in, MemWrite_in, MemToReg_in, AluSrc_in, Halt_in;
    logic [3:0] AluOp_in;

    logic [DATA_W-1:0] PC_out, IR_out, R1_out, R2_out, Imm_out;
    logic [4:0] WAdr_out;
    logic R1_CF_out, R2_CF_out, RegWrite_out, MemWrite_out, MemToReg_out, AluSrc_out, Halt_out;
    logic [3:0] AluOp_out;
    logic Valid_out, Bubble_out, Stall_Err;
    logic [15:0] Stall_Cnt, Flush_Cnt, Instr_Cnt;

    logic [DATA_W-1:0] s_pc, s_ir, s_r1, s_r2, s_imm;
    logic [4:0] s_wadr;
    logic s_r1cf, s_r2cf, s_rw, s_mw, s_m2r, s_as, s_halt;
    logic [3:0] s_aluop;
    logic s_valid, s_bub, s_err;
    logic [SCNT_W-1:0] s_stall_cnt, s_flush_cnt, s_instr_cnt;

    always #5 CLK = ~CLK;

    id_ex_pipeline_register #(.DATA_W(DATA_W), .CNT_W(16), .STALL_LIMIT(LIMIT)) dut (
        .CLK(CLK), .CLR_N(CLR_N), .EN(EN), .Stall_PC_ID(Stall_PC_ID), .Flush(Flush), .Cnt_Clr(Cnt_Clr),
        .PC_in(PC_in), .IR_in(IR_in), .R1_in(R1_in), .R2_in(R2_in), .Imm_in(Imm_in),
        .WAdr_in(WAdr_in), .R1_CF_in(R1_CF_in), .R2_CF_in(R2_CF_in), .RegWrite_in(RegWrite_in),
        .MemWrite_in(MemWrite_in), .MemToReg_in(MemToReg_in), .AluSrc_in(AluSrc_in), .Halt_in(Halt_in),
        .AluOp_in(AluOp_in),
        .PC_out(PC_out), .IR_out(IR_out), .R1_out(R1_out), .R2_out(R2_out), .Imm_out(Imm_out),
        .WAdr_out(WAdr_out), .R1_CF_out(R1_CF_out), .R2_CF_out(R2_CF_out), .RegWrite_out(RegWrite_out),
        .MemWrite_out(MemWrite_out), .MemToReg_out(MemToReg_out), .AluSrc_out(AluSrc_out),
        .Halt_out(Halt_out), .AluOp_out(AluOp_out), .Valid_out(Valid_out), .Bubble_out(Bubble_out),
        .Stall_Cnt(Stall_Cnt), .Flush_Cnt(Flush_Cnt), .Instr_Cnt(Instr_Cnt), .Stall_Err(Stall_Err)
    );

    // Narrow-counter instance sharing the same stimulus, so saturation is reachable quickly.
    id_ex_pipeline_register #(.DATA_W(DATA_W), .CNT_W(SCNT_W), .STALL_LIMIT(LIMIT)) dut_s (
        .CLK(CLK), .CLR_N(CLR_N), .EN(EN), .Stall_PC_ID(Stall_PC_ID), .Flush(Flush), .Cnt_Clr(Cnt_Clr),
        .PC_in(PC_in), .IR_in(IR_in), .R1_in(R1_in), .R2_in(R2_in), .Imm_in(Imm_in),
        .WAdr_in(WAdr_in), .R1_CF_in(R1_CF_in), .R2_CF_in(R2_CF_in), .RegWrite_in(RegWrite_in),
        .MemWrite_in(MemWrite_in), .MemToReg_in(MemToReg_in), .AluSrc_in(AluSrc_in), .Halt_in(Halt_in),
        .AluOp_in(AluOp_in),
        .PC_out(s_pc), .IR_out(s_ir), .R1_out(s_r1), .R2_out(s_r2), .Imm_out(s_imm),
        .WAdr_out(s_wadr), .R1_CF_out(s_r1cf), .R2_CF_out(s_r2cf), .RegWrite_out(s_rw),
        .MemWrite_out(s_mw), .MemToReg_out(s_m2r), .AluSrc_out(s_as),
        .Halt_out(s_halt), .AluOp_out(s_aluop), .Valid_out(s_valid), .Bubble_out(s_bub),
        .Stall_Cnt(s_stall_cnt), .Flush_Cnt(s_flush_cnt), .Instr_Cnt(s_instr_cnt), .Stall_Err(s_err)
    );

    // Reference model: expected EX slot plus unbounded event counts
    logic [DATA_W-1:0] e_pc, e_ir, e_r1, e_r2, e_imm;
    logic [4:0] e_wadr;
    logic e_r1cf, e_r2cf, e_rw, e_mw, e_m2r, e_as, e_halt, e_valid, e_bub, e_err, e_chk_data;
    logic [3:0] e_aluop;
    int n_fc, n_sc, n_ic, run_len;

    int compared = 0;
    int mismatched = 0;

    function automatic logic [63:0] cap(input int n, input int maxv);
        return (n > maxv) ? 64'(maxv) : 64'(n);
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        e_pc = '0; e_ir = '0; e_r1 = '0; e_r2 = '0; e_imm = '0; e_wadr = '0;
        e_r1cf = 0; e_r2cf = 0; e_rw = 0; e_mw = 0; e_m2r = 0; e_as = 0; e_halt = 0;
        e_aluop = '0; e_valid = 0; e_bub = 0; e_err = 0; e_chk_data = 1;
        n_fc = 0; n_sc = 0; n_ic = 0; run_len = 0;
    endtask

    // Applies one clock's worth of rules to the inputs currently driven.
    task automatic model_step();
        bit bubble, stall_act;
        if (!EN) return;
        bubble    = Flush || Stall_PC_ID;
        stall_act = !Flush && Stall_PC_ID;
        e_pc = PC_in;
        if (bubble) begin
            e_ir = '0; e_wadr = '0; e_r1cf = 0; e_r2cf = 0; e_rw = 0; e_mw = 0;
            e_m2r = 0; e_as = 0; e_halt = 0; e_aluop = '0; e_valid = 0; e_bub = 1;
            e_chk_data = 0;
        end else begin
            e_ir = IR_in; e_r1 = R1_in; e_r2 = R2_in; e_imm = Imm_in; e_wadr = WAdr_in;
            e_r1cf = R1_CF_in; e_r2cf = R2_CF_in; e_rw = RegWrite_in; e_mw = MemWrite_in;
            e_m2r = MemToReg_in; e_as = AluSrc_in; e_halt = Halt_in; e_aluop = AluOp_in;
            e_valid = 1; e_bub = 0; e_chk_data = 1;
        end
        run_len = stall_act ? run_len + 1 : 0;
        if (Cnt_Clr) begin
            n_fc = 0; n_sc = 0; n_ic = 0; e_err = 0;
        end else begin
            if (Flush) n_fc++;
            else if (Stall_PC_ID) n_sc++;
            else n_ic++;
            if (stall_act && run_len >= LIMIT) e_err = 1;
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".pc"}, 64'(PC_out), 64'(e_pc));
        chk({tag, ".ir"}, 64'(IR_out), 64'(e_ir));
        if (e_chk_data) begin
            chk({tag, ".r1"}, 64'(R1_out), 64'(e_r1));
            chk({tag, ".r2"}, 64'(R2_out), 64'(e_r2));
            chk({tag, ".imm"}, 64'(Imm_out), 64'(e_imm));
        end
        chk({tag, ".wadr"}, 64'(WAdr_out), 64'(e_wadr));
        chk({tag, ".ctl"}, 64'({R1_CF_out, R2_CF_out, RegWrite_out, MemWrite_out, MemToReg_out,
                                AluSrc_out, Halt_out, AluOp_out}),
                           64'({e_r1cf, e_r2cf, e_rw, e_mw, e_m2r, e_as, e_halt, e_aluop}));
        chk({tag, ".valid"}, 64'(Valid_out), 64'(e_valid));
        chk({tag, ".bubble"}, 64'(Bubble_out), 64'(e_bub));
        chk({tag, ".stall_cnt"}, 64'(Stall_Cnt), cap(n_sc, MAX_D));
        chk({tag, ".flush_cnt"}, 64'(Flush_Cnt), cap(n_fc, MAX_D));
        chk({tag, ".instr_cnt"}, 64'(Instr_Cnt), cap(n_ic, MAX_D));
        chk({tag, ".stall_err"}, 64'(Stall_Err), 64'(e_err));
        chk({tag, ".s_stall_cnt"}, 64'(s_stall_cnt), cap(n_sc, MAX_S));
        chk({tag, ".s_flush_cnt"}, 64'(s_flush_cnt), cap(n_fc, MAX_S));
        chk({tag, ".s_instr_cnt"}, 64'(s_instr_cnt), cap(n_ic, MAX_S));
        chk({tag, ".s_stall_err"}, 64'(s_err), 64'(e_err));
    endtask

    task automatic randomize_data();
        PC_in = $urandom; IR_in = $urandom; R1_in = $urandom; R2_in = $urandom; Imm_in = $urandom;
        WAdr_in = 5'($urandom); AluOp_in = 4'($urandom);
        {R1_CF_in, R2_CF_in, RegWrite_in, MemWrite_in, MemToReg_in, AluSrc_in, Halt_in} = 7'($urandom);
    endtask

    task automatic cycle(input string tag);
        model_step();
        @(posedge CLK);
        #1;
        check_all(tag);
    endtask

    initial begin
        CLR_N = 0; EN = 0; Stall_PC_ID = 0; Flush = 0; Cnt_Clr = 0;
        randomize_data();
        repeat (2) @(posedge CLK);
        #1;
        model_reset();
        check_all("reset");

        // First pass after reset
        CLR_N = 1; EN = 1;
        randomize_data();
        PC_in = 32'h0000_0004; IR_in = 32'h8C22_0000; RegWrite_in = 1;
        cycle("pass1");
        chk("pass1.pc_const", 64'(PC_out), 64'h4);
        chk("pass1.ir_const", 64'(IR_out), 64'h8C22_0000);
        chk("pass1.valid_const", 64'(Valid_out), 64'd1);
        chk("pass1.instr_const", 64'(Instr_Cnt), 64'd1);

        // Single stall squashes controls
        randomize_data();
        Stall_PC_ID = 1; RegWrite_in = 1; WAdr_in = 5'd5;
        cycle("stall1");
        chk("stall1.rw_const", 64'(RegWrite_out), 64'd0);
        chk("stall1.wadr_const", 64'(WAdr_out), 64'd0);
        chk("stall1.bub_const", 64'(Bubble_out), 64'd1);
        chk("stall1.scnt_const", 64'(Stall_Cnt), 64'd1);
        chk("stall1.icnt_const", 64'(Instr_Cnt), 64'd1);

        // Flush beats stall
        randomize_data();
        Flush = 1; Stall_PC_ID = 1;
        cycle("flush1");
        chk("flush1.fcnt_const", 64'(Flush_Cnt), 64'd1);
        chk("flush1.scnt_const", 64'(Stall_Cnt), 64'd1);
        chk("flush1.pc_follows", 64'(PC_out), 64'(PC_in));

        // Watchdog: three consecutive stalls
        Flush = 0; Stall_PC_ID = 0; randomize_data();
        cycle("wd.pass");
        for (int i = 1; i <= 3; i++) begin
            Stall_PC_ID = 1; randomize_data();
            cycle($sformatf("wd.stall%0d", i));
            chk($sformatf("wd.err_after%0d", i), 64'(Stall_Err), (i >= 3) ? 64'd1 : 64'd0);
        end
        Stall_PC_ID = 0;
        for (int i = 0; i < 2; i++) begin
            randomize_data();
            cycle("wd.hold");
            chk("wd.err_sticky", 64'(Stall_Err), 64'd1);
        end
        Cnt_Clr = 1; randomize_data();
        cycle("wd.clr");
        chk("wd.clr_err", 64'(Stall_Err), 64'd0);
        chk("wd.clr_cnts", 64'({Stall_Cnt, Flush_Cnt, Instr_Cnt}), 64'd0);
        Cnt_Clr = 0;

        // Freeze with EN low, flush, clear and new data pending
        EN = 0; Flush = 1; Cnt_Clr = 1;
        for (int i = 0; i < 2; i++) begin
            randomize_data();
            cycle("freeze");
        end
        EN = 1; Flush = 0; Cnt_Clr = 0;

        // Saturation of the narrow counter under repeated stalls
        Stall_PC_ID = 1;
        for (int i = 0; i < 10; i++) begin
            randomize_data();
            cycle("sat");
        end
        chk("sat.s_stall_cnt_max", 64'(s_stall_cnt), 64'd7);
        Stall_PC_ID = 0;

        // Randomized operation with occasional mid-cycle resets
        for (int i = 0; i < 500; i++) begin
            randomize_data();
            EN          = ($urandom_range(0, 7) != 0);
            Flush       = ($urandom_range(0, 7) == 0);
            Stall_PC_ID = ($urandom_range(0, 2) == 0);
            Cnt_Clr     = ($urandom_range(0, 31) == 0);
            cycle("rand");
            if ($urandom_range(0, 63) == 0) begin
                CLR_N = 0;
                #2;
                model_reset();
                check_all("rand.async_rst");
                CLR_N = 1;
            end
        end

        // Asynchronous reset between edges while a real instruction is held
        EN = 1; Flush = 0; Stall_PC_ID = 0; Cnt_Clr = 0;
        randomize_data();
        cycle("prerst");
        chk("prerst.valid", 64'(Valid_out), 64'd1);
        CLR_N = 0;
        #2;
        model_reset();
        check_all("midrst");
        chk("midrst.valid", 64'(Valid_out), 64'd0);
        CLR_N = 1;
        randomize_data();
        cycle("postrst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
